// File: rtl/raycast_pkg.sv
`default_nettype none
// ============================================================================
// Module      : raycast_pkg
// Description : Shared types and constants for the raycaster player/map blocks:
//               FSM state encoding, heading quadrants, Q8.8 geometry constants.
// Revision    : 1.0 - initial release
// ============================================================================
package raycast_pkg;

  // Player controller FSM states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TURN = 2'd1,
    CALC = 2'd2,
    REQ  = 2'd3
  } state_t;

  // Direction of travel, one per minimap heading quadrant
  typedef enum logic [1:0] {
    DIR_POS_X = 2'd0,
    DIR_POS_Y = 2'd1,
    DIR_NEG_X = 2'd2,
    DIR_NEG_Y = 2'd3
  } heading_t;

  localparam int ANGLE_W    = 9;
  localparam int ANGLE_MAX  = 360;
  localparam int QUAD_45    = 45;
  localparam int QUAD_135   = 135;
  localparam int QUAD_225   = 225;
  localparam int QUAD_315   = 315;

  localparam int Q_WIDTH    = 16;   // Q8.8 position width
  localparam int TILE_SHIFT = 8;    // integer tile index starts at bit 8
  localparam int MAP_DIM    = 16;   // map is MAP_DIM x MAP_DIM tiles

  // Map a heading in degrees to the quadrant direction of travel
  function automatic heading_t heading_of(input logic [ANGLE_W-1:0] angle);
    heading_t h;
    if (angle < ANGLE_W'(QUAD_45) || angle >= ANGLE_W'(QUAD_315)) h = DIR_POS_X;
    else if (angle < ANGLE_W'(QUAD_135))                          h = DIR_POS_Y;
    else if (angle < ANGLE_W'(QUAD_225))                          h = DIR_NEG_X;
    else                                                          h = DIR_NEG_Y;
    return h;
  endfunction

endpackage
`default_nettype wire

// File: rtl/angle_wrap_step.sv
`default_nettype none
// ============================================================================
// Module      : angle_wrap_step
// Description : Combinational +/- step on a 0-359 degree angle with modulo-360
//               wrap. Increment and decrement together cancel.
// Revision    : 1.0 - initial release
// ============================================================================
module angle_wrap_step
  import raycast_pkg::*;
(
  input  logic [ANGLE_W-1:0] angle_in,
  input  logic [ANGLE_W-1:0] step,
  input  logic               inc,
  input  logic               dec,
  output logic [ANGLE_W-1:0] angle_out
);

  logic [ANGLE_W:0] sum;

  // Wrapped step: add/subtract and fold back into 0..359
  always_comb begin
    sum       = {1'b0, angle_in} + {1'b0, step};
    angle_out = angle_in;
    if (inc && !dec) begin
      if (sum >= (ANGLE_W+1)'(ANGLE_MAX))
        angle_out = ANGLE_W'(sum - (ANGLE_W+1)'(ANGLE_MAX));
      else
        angle_out = sum[ANGLE_W-1:0];
    end else if (dec && !inc) begin
      if (angle_in < step)
        angle_out = ANGLE_W'({1'b0, angle_in} + (ANGLE_W+1)'(ANGLE_MAX) - {1'b0, step});
      else
        angle_out = angle_in - step;
    end
  end

endmodule
`default_nettype wire

// File: rtl/player_motion_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : player_motion_ctrl
// Description : Per-frame player state controller. Applies turn/move buttons
//               on each frame tick and validates the move against the shared
//               world-map tile lookup via a request/grant port.
// Revision    : 1.0 - initial release
// ============================================================================
module player_motion_ctrl
  import raycast_pkg::*;
#(
  parameter logic [15:0] START_X     = 16'h0180,
  parameter logic [15:0] START_Y     = 16'h0180,
  parameter logic [8:0]  START_ANGLE = 9'd0,
  parameter logic [15:0] MOVE_STEP   = 16'h0010,
  parameter logic [15:0] RADIUS      = 16'h0040,
  parameter logic [8:0]  TURN_STEP   = 9'd3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frame_tick,
  input  logic        btn_fwd,
  input  logic        btn_back,
  input  logic        btn_left,
  input  logic        btn_right,
  output logic        map_req,
  input  logic        map_gnt,
  output logic [3:0]  map_tile_x,
  output logic [3:0]  map_tile_y,
  input  logic        map_wall,
  output logic [15:0] playerX,
  output logic [15:0] playerY,
  output logic [8:0]  playerAngle,
  output logic        busy
);

  state_t      state;
  logic [3:0]  btn_q;       // {fwd, back, left, right} latched at the frame tick
  logic        axis_y_q;    // moving axis of the pending request
  logic [15:0] cand_q;      // candidate position waiting for the map verdict

  logic [8:0]  angle_next;

  heading_t          heading;
  logic              move_en;
  logic              move_y;
  logic              move_neg;
  logic [15:0]       pos_sel;
  logic [15:0]       cand;
  logic signed [16:0] probe;
  logic              probe_ok;

  angle_wrap_step u_turn (
    .angle_in  (playerAngle),
    .step      (TURN_STEP),
    .inc       (btn_q[0]),
    .dec       (btn_q[1]),
    .angle_out (angle_next)
  );

  // Candidate move and collision probe derived from the (already updated) angle
  always_comb begin
    heading  = heading_of(playerAngle);
    move_en  = btn_q[3] ^ btn_q[2];
    move_y   = (heading == DIR_POS_Y) || (heading == DIR_NEG_Y);
    // Backward travel inverts the quadrant sign; only meaningful when move_en
    move_neg = ((heading == DIR_NEG_X) || (heading == DIR_NEG_Y)) ^ btn_q[2];
    pos_sel  = move_y ? playerY : playerX;
    if (move_neg) begin
      cand  = pos_sel - MOVE_STEP;
      probe = $signed({1'b0, cand}) - $signed({1'b0, RADIUS});
    end else begin
      cand  = pos_sel + MOVE_STEP;
      probe = $signed({1'b0, cand}) + $signed({1'b0, RADIUS});
    end
    // In bounds: non-negative and below 16.0 tiles
    probe_ok = !probe[16] && (probe[15:12] == 4'd0);
  end

  // Frame FSM with all outputs registered
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      btn_q       <= 4'd0;
      axis_y_q    <= 1'b0;
      cand_q      <= 16'd0;
      map_req     <= 1'b0;
      map_tile_x  <= 4'd0;
      map_tile_y  <= 4'd0;
      playerX     <= START_X;
      playerY     <= START_Y;
      playerAngle <= START_ANGLE;
      busy        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (frame_tick) begin
            btn_q <= {btn_fwd, btn_back, btn_left, btn_right};
            busy  <= 1'b1;
            state <= TURN;
          end
        end
        TURN: begin
          playerAngle <= angle_next;
          state       <= CALC;
        end
        CALC: begin
          if (move_en && probe_ok) begin
            cand_q     <= cand;
            axis_y_q   <= move_y;
            map_tile_x <= move_y ? playerX[11:8] : probe[11:8];
            map_tile_y <= move_y ? probe[11:8]   : playerY[11:8];
            map_req    <= 1'b1;
            state      <= REQ;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        REQ: begin
          if (map_gnt) begin
            if (!map_wall) begin
              if (axis_y_q) playerY <= cand_q;
              else          playerX <= cand_q;
            end
            map_req <= 1'b0;
            busy    <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_player_motion_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_player_motion_ctrl
// Description : Directed self-checking bench for player_motion_ctrl. Four
//               instances with different start conditions share buttons and
//               reset; each has its own tick/grant and a wall-at-column-0 map.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_player_motion_ctrl;

  localparam logic [15:0] SX [4] = '{16'h0180, 16'h014F, 16'h0180, 16'h0180};
  localparam logic [15:0] SY [4] = '{16'h0180, 16'h0180, 16'h0FC0, 16'h0180};
  localparam logic [8:0]  SA [4] = '{9'd0, 9'd180, 9'd90, 9'd358};

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fwd, back, left, right;
  logic [3:0]  tick, gnt, req, busy, wall;
  logic [3:0]  tx [4];
  logic [3:0]  ty [4];
  logic [15:0] px [4];
  logic [15:0] py [4];
  logic [8:0]  pa [4];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    assign wall[g] = (tx[g] == 4'd0);
    player_motion_ctrl #(
      .START_X     (SX[g]),
      .START_Y     (SY[g]),
      .START_ANGLE (SA[g])
    ) u_dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .frame_tick  (tick[g]),
      .btn_fwd     (fwd),
      .btn_back    (back),
      .btn_left    (left),
      .btn_right   (right),
      .map_req     (req[g]),
      .map_gnt     (gnt[g]),
      .map_tile_x  (tx[g]),
      .map_tile_y  (ty[g]),
      .map_wall    (wall[g]),
      .playerX     (px[g]),
      .playerY     (py[g]),
      .playerAngle (pa[g]),
      .busy        (busy[g])
    );
  end

  task automatic set_btns(input logic f, input logic b, input logic l, input logic r);
    fwd = f; back = b; left = l; right = r;
  endtask

  // Returns at the negedge right after edge T (cycle T+1)
  task automatic start_frame(input int idx);
    @(negedge clk) tick[idx] = 1'b1;
    @(negedge clk) tick[idx] = 1'b0;
  endtask

  task automatic wait_req(input int idx, output bit got);
    got = 1'b0;
    for (int n = 0; n < 20 && !got; n++) begin
      if (req[idx]) got = 1'b1;
      else @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if ({px[0], py[0]} !== {16'h0180, 16'h0180}) begin failures++;
      $display("FAIL reset_pos0: got %h/%h expected 0180/0180", px[0], py[0]); end
    checks++; if (pa[0] !== 9'd0) begin failures++;
      $display("FAIL reset_angle0: got %0d expected 0", pa[0]); end
    checks++; if ({req, busy} !== 8'h00) begin failures++;
      $display("FAIL reset_req_busy: got req=%b busy=%b expected 0000/0000", req, busy); end
    checks++; if ({tx[0], ty[0]} !== 8'h00) begin failures++;
      $display("FAIL reset_tile: got %h,%h expected 0,0", tx[0], ty[0]); end
    checks++; if ({px[1], pa[1], py[2], pa[2], pa[3]} !== {16'h014F, 9'd180, 16'h0FC0, 9'd90, 9'd358}) begin
      failures++;
      $display("FAIL reset_params: got x1=%h a1=%0d y2=%h a2=%0d a3=%0d expected 014F 180 0FC0 90 358",
               px[1], pa[1], py[2], pa[2], pa[3]); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_forward;
    set_btns(1, 0, 0, 0);
    start_frame(0);
    checks++; if ({busy[0], req[0]} !== 2'b10) begin failures++;
      $display("FAIL fwd_T1: got busy=%b req=%b expected 1/0", busy[0], req[0]); end
    @(negedge clk);
    checks++; if (req[0] !== 1'b0) begin failures++;
      $display("FAIL fwd_T2_req: got %b expected 0", req[0]); end
    @(negedge clk);
    checks++; if ({req[0], tx[0], ty[0]} !== {1'b1, 4'd1, 4'd1}) begin failures++;
      $display("FAIL fwd_T3_req_tile: got req=%b tile=%0d,%0d expected 1 at 1,1", req[0], tx[0], ty[0]); end
    gnt[0] = 1'b1;
    @(negedge clk) gnt[0] = 1'b0;
    checks++; if ({px[0], py[0]} !== {16'h0190, 16'h0180}) begin failures++;
      $display("FAIL fwd_commit: got %h/%h expected 0190/0180", px[0], py[0]); end
    checks++; if ({req[0], busy[0]} !== 2'b00) begin failures++;
      $display("FAIL fwd_done: got req=%b busy=%b expected 0/0", req[0], busy[0]); end
  endtask

  task automatic test_grant_stall;
    bit got;
    set_btns(1, 0, 0, 0);
    start_frame(0);
    wait_req(0, got);
    checks++; if (!got) begin failures++;
      $display("FAIL stall_req: got no map_req expected map_req=1"); end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({req[0], busy[0], tx[0], ty[0]} !== {1'b1, 1'b1, 4'd1, 4'd1}) begin failures++;
        $display("FAIL stall_hold[%0d]: got req=%b busy=%b tile=%0d,%0d expected 1 1 1,1",
                 i, req[0], busy[0], tx[0], ty[0]); end
      @(negedge clk) tick[0] = (i == 1);
    end
    tick[0] = 1'b0;
    gnt[0] = 1'b1;
    @(negedge clk) gnt[0] = 1'b0;
    checks++; if (px[0] !== 16'h01A0) begin failures++;
      $display("FAIL stall_commit: got %h expected 01A0", px[0]); end
    repeat (6) @(negedge clk);
    checks++; if ({px[0], req[0], busy[0]} !== {16'h01A0, 2'b00}) begin failures++;
      $display("FAIL stall_no_queue: got x=%h req=%b busy=%b expected 01A0 0 0", px[0], req[0], busy[0]); end
  endtask

  task automatic test_angle_wrap;
    bit seen;
    set_btns(0, 0, 1, 0);
    start_frame(0);
    checks++; if (pa[0] !== 9'd0) begin failures++;
      $display("FAIL wrap_left_T1: got %0d expected 0", pa[0]); end
    @(negedge clk);
    checks++; if (pa[0] !== 9'd357) begin failures++;
      $display("FAIL wrap_left: got %0d expected 357", pa[0]); end
    seen = 1'b0;
    repeat (4) begin @(negedge clk); if (req[0]) seen = 1'b1; end
    checks++; if ({seen, busy[0]} !== 2'b00) begin failures++;
      $display("FAIL wrap_left_idle: got req_seen=%b busy=%b expected 0/0", seen, busy[0]); end
    set_btns(0, 0, 1, 1);
    start_frame(0);
    seen = 1'b0;
    repeat (5) begin @(negedge clk); if (req[0]) seen = 1'b1; end
    checks++; if ({pa[0], seen} !== {9'd357, 1'b0}) begin failures++;
      $display("FAIL wrap_both: got angle=%0d req_seen=%b expected 357/0", pa[0], seen); end
    set_btns(0, 0, 0, 1);
    start_frame(3);
    @(negedge clk);
    checks++; if (pa[3] !== 9'd1) begin failures++;
      $display("FAIL wrap_right: got %0d expected 1", pa[3]); end
  endtask

  task automatic test_wall;
    bit got;
    set_btns(1, 0, 0, 0);
    start_frame(1);
    wait_req(1, got);
    checks++; if ({got, tx[1], ty[1]} !== {1'b1, 4'd0, 4'd1}) begin failures++;
      $display("FAIL wall_req_tile: got req=%b tile=%0d,%0d expected 1 at 0,1", got, tx[1], ty[1]); end
    gnt[1] = 1'b1;
    @(negedge clk) gnt[1] = 1'b0;
    checks++; if ({px[1], py[1], pa[1]} !== {16'h014F, 16'h0180, 9'd180}) begin failures++;
      $display("FAIL wall_blocked: got x=%h y=%h a=%0d expected 014F 0180 180", px[1], py[1], pa[1]); end
    checks++; if ({busy[1], req[1]} !== 2'b00) begin failures++;
      $display("FAIL wall_done: got busy=%b req=%b expected 0/0", busy[1], req[1]); end
  endtask

  task automatic test_bounds;
    bit seen;
    set_btns(1, 0, 0, 0);
    start_frame(2);
    seen = 1'b0;
    repeat (6) begin @(negedge clk); if (req[2]) seen = 1'b1; end
    checks++; if (seen !== 1'b0) begin failures++;
      $display("FAIL bounds_no_req: got req_seen=%b expected 0", seen); end
    checks++; if ({px[2], py[2], busy[2]} !== {16'h0180, 16'h0FC0, 1'b0}) begin failures++;
      $display("FAIL bounds_hold: got x=%h y=%h busy=%b expected 0180 0FC0 0", px[2], py[2], busy[2]); end
  endtask

  task automatic test_reset_mid_req;
    bit got;
    set_btns(1, 0, 0, 0);
    start_frame(0);
    wait_req(0, got);
    checks++; if ({got, tx[0], ty[0]} !== {1'b1, 4'd1, 4'd1}) begin failures++;
      $display("FAIL midreq_req: got req=%b tile=%0d,%0d expected 1 at 1,1", got, tx[0], ty[0]); end
    rst_n = 1'b0;
    @(negedge clk);
    checks++; if ({px[0], py[0], pa[0]} !== {16'h0180, 16'h0180, 9'd0}) begin failures++;
      $display("FAIL midreq_reset_pos: got x=%h y=%h a=%0d expected 0180 0180 0", px[0], py[0], pa[0]); end
    checks++; if ({req[0], busy[0], tx[0], ty[0]} !== 10'd0) begin failures++;
      $display("FAIL midreq_reset_port: got req=%b busy=%b tile=%0d,%0d expected 0 0 0,0",
               req[0], busy[0], tx[0], ty[0]); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if ({req[0], px[0]} !== {1'b0, 16'h0180}) begin failures++;
      $display("FAIL midreq_after: got req=%b x=%h expected 0 0180", req[0], px[0]); end
  endtask

  initial begin
    rst_n = 1'b0;
    tick  = 4'd0;
    gnt   = 4'd0;
    set_btns(0, 0, 0, 0);
    test_reset;
    test_forward;
    test_grant_stall;
    test_angle_wrap;
    test_wall;
    test_bounds;
    test_reset_mid_req;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/player_motion_ctrl.md
# player_motion_ctrl

Per-frame player state controller. It owns `playerX`, `playerY` and `playerAngle`, which feed the minimap and raycaster. On each frame tick it applies turn and move buttons, then validates the candidate position against the shared world-map tile lookup through a request/grant port. The port is shared with other map consumers through the map arbiter. Movement is quantised to the four minimap heading quadrants, so the minimap direction indicator always matches the direction of travel.

## Interface
Parameters:
- `START_X`, default 16'h0180: reset X, Q8.8 (1.5 tiles)
- `START_Y`, default 16'h0180: reset Y, Q8.8
- `START_ANGLE`, default 9'd0: reset heading, degrees 0-359
- `MOVE_STEP`, default 16'h0010: displacement per frame, Q8.8 (1/16 tile)
- `RADIUS`, default 16'h0040: collision probe offset ahead of player, Q8.8
- `TURN_STEP`, default 9'd3: degrees per frame, must be < 360

Ports:
- `clk` in 1: sole clock
- `rst_n` in 1: synchronous, active-low reset
- `frame_tick` in 1: single-cycle pulse at vblank start
- `btn_fwd`, `btn_back`, `btn_left`, `btn_right` in 1 each: level inputs, sampled only on an accepted `frame_tick`
- `map_req` out 1: tile lookup request
- `map_gnt` in 1: lookup grant; `map_wall` is valid in the same cycle
- `map_tile_x`, `map_tile_y` out 4 each: tile address, held stable while `map_req`=1
- `map_wall` in 1: 1 = wall at the requested tile
- `playerX`, `playerY` out 16: Q8.8 unsigned position, registered
- `playerAngle` out 9: heading 0-359, registered
- `busy` out 1: high in any state other than IDLE

## Operation
- FSM states: IDLE, TURN, CALC, REQ.
- **IDLE**
  - On `frame_tick`, latch the buttons into `btn_q` and go to TURN.
  - `frame_tick` in any other state is ignored. It is not queued.
- **TURN**
  - left only: angle -= TURN_STEP, wrapping below 0 by +360.
  - right only: angle += TURN_STEP, wrapping at ≥360 by -360.
  - Both or neither pressed: angle unchanged.
  - Always go to CALC.
- **CALC** uses the updated angle.
  - Axis/sign by quadrant:
    - angle < 45 or ≥ 315: +X
    - 45–134: +Y
    - 135–224: -X
    - 225–314: -Y
  - fwd only: sign as listed. back only: sign inverted. Both or neither: no move, go to IDLE.
  - Candidate = pos ± MOVE_STEP on the selected axis.
  - Probe = candidate ± RADIUS in the same direction, computed as a 17-bit signed value.
  - Probe < 0 or probe ≥ 16.0 (16'h1000): reject, go to IDLE, `map_req` never asserted.
  - Otherwise drive `map_tile_x`/`map_tile_y` = probe[11:8] on the moving axis and the current pos[11:8] on the other axis, then go to REQ.
- **REQ**
  - `map_req`=1 with the address held.
  - On the edge where `map_req & map_gnt`:
    - If `map_wall`=0, commit the candidate to the moving axis.
    - Go to IDLE either way.
  - No timeout; waits on `map_gnt` indefinitely.
- Only one axis is updated per frame.
- The angle commits even when the move is rejected.

## Timing
- Reset values: `playerX`=START_X, `playerY`=START_Y, `playerAngle`=START_ANGLE, `map_req`=0, tile outputs 0, `busy`=0, state IDLE.
- `frame_tick` sampled at edge T:
  - `busy`=1 from T+1.
  - New angle visible from T+2.
  - `map_req` rises at T+3.
- Grant sampled at edge G:
  - Position updated and `map_req`=0 from G+1.
  - `busy`=0 from G+1.
- Minimum tick-to-position latency: 4 cycles. Must complete well within vblank.
- No-move or out-of-bounds frames return to IDLE at T+3.
- `rst_n` low at any edge, including mid-REQ, forces reset values at that edge. `map_req` drops in the following cycle, with no handshake completion.
- Outputs change only on frame completion, so renderers see stable values during active video.

## Structure
- Shared package `raycast_pkg`:
  - state enum
  - `ANGLE_MAX`=360
  - quadrant boundary constants 45/135/225/315
  - Q8.8 width and `TILE_SHIFT`=8 localparams
  - `MAP_DIM`=16
- Sub-module `angle_wrap_step`: combinational ±step with modulo-360 wrap, reused by the raycaster ray-angle sweep.

## Test plan
- Reset, then forward at angle 0, map empty at (1,1):
  - probe 16'h01D0 → request tile (1,1).
  - After grant, `playerX`=16'h0190, `playerY`=16'h0180.
- Angle 180 with START_X=16'h014F, map model wall at column 0, forward:
  - Request tile (0,1); `map_wall`=1.
  - `playerX` stays 16'h014F, `busy` falls after grant.
- Angle wrap:
  - angle 0, left for one frame → 357.
  - angle 358, right → 1.
  - left+right → unchanged, no `map_req`.
- Bounds: START_Y=16'h0FC0, angle 90, forward:
  - probe ≥ 16'h1000, `map_req` never asserted, Y unchanged.
- Grant stall: hold `map_gnt`=0 for 5 cycles.
  - `map_req` and the tile address stay stable, `busy`=1.
  - A second `frame_tick` during the stall is ignored: exactly one position update.
- Assert `rst_n`=0 mid-REQ:
  - All outputs return to reset values at that edge.
  - `map_req`=0 next cycle.
